// File: rtl/sram_arb_pkg.sv
// Shared types and default timing for the cartridge SRAM arbiter.
package sram_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CART = 2'd1,
    UC   = 2'd2
  } state_e;

  // Which requester owns the access in flight.
  typedef enum logic {
    OWN_CART = 1'b0,
    OWN_UC   = 1'b1
  } owner_e;

  // Default access shape: 4 clocks, WE low in phases 1..2.
  localparam int ACC_CYCLES_DEF = 4;
  localparam int WE_FIRST_DEF   = 1;
  localparam int WE_LAST_DEF    = 2;

  // One SRAM command as latched from a requester.
  typedef struct packed {
    logic        we;
    logic [14:0] addr;
    logic [7:0]  wdata;
  } cmd_t;

  // Map a busy state to the requester that owns it.
  function automatic owner_e state_owner(input state_e s);
    return (s == UC) ? OWN_UC : OWN_CART;
  endfunction

endpackage

// File: rtl/sram_seq.sv
// Fixed-length SRAM access sequencer: phase counter plus registered strobes.
// A start pulse begins phase 0 on the next cycle; a start coinciding with
// the last phase chains the next access with no idle cycle.
module sram_seq
  import sram_arb_pkg::*;
#(
  parameter int ACC_CYCLES = ACC_CYCLES_DEF,
  parameter int WE_FIRST   = WE_FIRST_DEF,
  parameter int WE_LAST    = WE_LAST_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,     // begin an access at this edge
  input  logic we_i,        // write access (valid with start_i)
  input  logic nowe_i,      // suppress the WE pulse (write protect)
  output logic cap_o,       // register ram_din at this edge
  output logic last_o,      // current cycle is the final phase
  output logic ram_oe_n_o,
  output logic ram_we_n_o,
  output logic ram_dq_oe_o
);

  localparam int PW = $clog2(ACC_CYCLES);
  localparam logic [PW-1:0] P_LAST = PW'(ACC_CYCLES - 1);
  localparam logic [PW-1:0] P_CAP  = PW'(ACC_CYCLES - 2);
  localparam logic [PW-1:0] P_WF   = PW'(WE_FIRST);
  localparam logic [PW-1:0] P_WL   = PW'(WE_LAST);

  logic          active_q, active_d;
  logic [PW-1:0] p_q, p_d;
  logic          we_q, we_d;
  logic          nowe_q, nowe_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic          dq_oe_q, dq_oe_d;

  // Next phase, then strobes decoded from the next phase so pins are flops.
  always_comb begin
    active_d = active_q;
    p_d      = p_q;
    we_d     = we_q;
    nowe_d   = nowe_q;
    if (start_i) begin
      active_d = 1'b1;
      p_d      = '0;
      we_d     = we_i;
      nowe_d   = nowe_i;
    end else if (active_q) begin
      if (p_q == P_LAST) begin
        active_d = 1'b0;
        p_d      = '0;
      end else begin
        p_d = p_q + 1'b1;
      end
      // Write protect is re-sampled during phase 0 for the remaining phases.
      if (p_q == '0) nowe_d = nowe_i;
    end
    oe_n_d  = !(active_d && !we_d);
    dq_oe_d = active_d && we_d;
    we_n_d  = !(active_d && we_d && !nowe_d && (p_d >= P_WF) && (p_d <= P_WL));
  end

  // Sequencer state and pin registers; reset truncates any access.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      p_q      <= '0;
      we_q     <= 1'b0;
      nowe_q   <= 1'b0;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
    end else begin
      active_q <= active_d;
      p_q      <= p_d;
      we_q     <= we_d;
      nowe_q   <= nowe_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      dq_oe_q  <= dq_oe_d;
    end
  end

  assign cap_o       = active_q && (p_q == P_CAP);
  assign last_o      = active_q && (p_q == P_LAST);
  assign ram_oe_n_o  = oe_n_q;
  assign ram_we_n_o  = we_n_q;
  assign ram_dq_oe_o = dq_oe_q;

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester SRAM arbiter: cart (strict priority, one-deep pending slot)
// and microcontroller byte port, sharing one fixed-length access sequencer.
//
// uc handshake (4-phase): uc_req rises with a stable command; uc_ack rises
// one cycle after the access ends and holds with uc_rdata valid; uc_req
// falls; uc_ack falls the cycle after uc_req is sampled low. A new uc access
// is only started while uc_ack is low.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ACC_CYCLES = ACC_CYCLES_DEF,
  parameter int WE_FIRST   = WE_FIRST_DEF,
  parameter int WE_LAST    = WE_LAST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cart_req,
  input  logic        cart_we,
  input  logic [14:0] cart_addr,
  input  logic [7:0]  cart_wdata,
  output logic [7:0]  cart_rdata,
  output logic        cart_done,
  input  logic        cart_wp,
  output logic        cart_ovf,
  input  logic        uc_req,
  input  logic        uc_we,
  input  logic [14:0] uc_addr,
  input  logic [7:0]  uc_wdata,
  output logic [7:0]  uc_rdata,
  output logic        uc_ack,
  output logic [14:0] ram_addr,
  output logic [7:0]  ram_dout,
  input  logic [7:0]  ram_din,
  output logic        ram_dq_oe,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output state_e      dbg_state,
  output logic        dbg_pend
);

  state_e      state_q, state_d;
  logic        pend_q, pend_d;
  cmd_t        pend_cmd_q, pend_cmd_d;
  logic        ovf_q, ovf_d;
  logic        acc_we_q, acc_we_d;
  logic [7:0]  cart_rdata_q, cart_rdata_d;
  logic [7:0]  uc_rdata_q, uc_rdata_d;
  logic        cart_done_q, cart_done_d;
  logic        uc_ack_q, uc_ack_d;
  logic [14:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_dout_q, ram_dout_d;

  cmd_t   cart_in, cart_cmd;
  logic   cart_want, take_cart, take_uc, start, start_we, nowe;
  logic   seq_cap, seq_last;
  owner_e own;

  // Arbitration, pending-slot bookkeeping and registered output updates.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_cmd_d   = pend_cmd_q;
    ovf_d        = ovf_q;
    acc_we_d     = acc_we_q;
    cart_rdata_d = cart_rdata_q;
    uc_rdata_d   = uc_rdata_q;
    cart_done_d  = 1'b0;
    uc_ack_d     = uc_ack_q;
    ram_addr_d   = ram_addr_q;
    ram_dout_d   = ram_dout_q;
    take_cart    = 1'b0;
    take_uc      = 1'b0;
    start_we     = 1'b0;

    // A same-cycle cart_req counts as pending so it can start immediately.
    cart_in   = '{we: cart_we, addr: cart_addr, wdata: cart_wdata};
    cart_want = pend_q || cart_req;
    cart_cmd  = pend_q ? pend_cmd_q : cart_in;
    own       = state_owner(state_q);

    case (state_q)
      IDLE: begin
        if (cart_want)                take_cart = 1'b1;
        else if (uc_req && !uc_ack_q) take_uc   = 1'b1;
      end
      CART, UC: begin
        if (seq_last) begin
          if (cart_want) take_cart = 1'b1;
          else           state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take_cart) begin
      state_d    = CART;
      ram_addr_d = cart_cmd.addr;
      ram_dout_d = cart_cmd.wdata;
      start_we   = cart_cmd.we;
    end else if (take_uc) begin
      state_d    = UC;
      ram_addr_d = uc_addr;
      ram_dout_d = uc_wdata;
      start_we   = uc_we;
    end
    start = take_cart || take_uc;
    if (start) acc_we_d = start_we;

    // One-deep cart slot: a request while full is lost and flagged.
    if (cart_req) begin
      if (pend_q) begin
        ovf_d = 1'b1;
      end else if (!take_cart) begin
        pend_d     = 1'b1;
        pend_cmd_d = cart_in;
      end
    end
    if (take_cart && pend_q) pend_d = 1'b0;

    // Read data lands in the owner's register; writes leave it untouched.
    if (seq_cap && !acc_we_q) begin
      if (own == OWN_CART) cart_rdata_d = ram_din;
      else                 uc_rdata_d   = ram_din;
    end

    if (seq_last && (state_q == CART)) cart_done_d = 1'b1;
    if (seq_last && (state_q == UC))   uc_ack_d    = 1'b1;
    else if (uc_ack_q && !uc_req)      uc_ack_d    = 1'b0;

    // Write protect only applies to accesses owned by the cart.
    nowe = cart_wp && (start ? take_cart : (state_q == CART));
  end

  // Arbiter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      pend_cmd_q   <= '0;
      ovf_q        <= 1'b0;
      acc_we_q     <= 1'b0;
      cart_rdata_q <= '0;
      uc_rdata_q   <= '0;
      cart_done_q  <= 1'b0;
      uc_ack_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_dout_q   <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_cmd_q   <= pend_cmd_d;
      ovf_q        <= ovf_d;
      acc_we_q     <= acc_we_d;
      cart_rdata_q <= cart_rdata_d;
      uc_rdata_q   <= uc_rdata_d;
      cart_done_q  <= cart_done_d;
      uc_ack_q     <= uc_ack_d;
      ram_addr_q   <= ram_addr_d;
      ram_dout_q   <= ram_dout_d;
    end
  end

  sram_seq #(
    .ACC_CYCLES(ACC_CYCLES),
    .WE_FIRST  (WE_FIRST),
    .WE_LAST   (WE_LAST)
  ) u_seq (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .we_i       (start_we),
    .nowe_i     (nowe),
    .cap_o      (seq_cap),
    .last_o     (seq_last),
    .ram_oe_n_o (ram_oe_n),
    .ram_we_n_o (ram_we_n),
    .ram_dq_oe_o(ram_dq_oe)
  );

  assign cart_rdata = cart_rdata_q;
  assign cart_done  = cart_done_q;
  assign cart_ovf   = ovf_q;
  assign uc_rdata   = uc_rdata_q;
  assign uc_ack     = uc_ack_q;
  assign ram_addr   = ram_addr_q;
  assign ram_dout   = ram_dout_q;
  assign dbg_state  = state_q;
  assign dbg_pend   = pend_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural 32 KiB SRAM.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cart_req, cart_we, cart_wp;
  logic [14:0] cart_addr;
  logic [7:0]  cart_wdata, cart_rdata;
  logic        cart_done, cart_ovf;
  logic        uc_req, uc_we, uc_ack;
  logic [14:0] uc_addr;
  logic [7:0]  uc_wdata, uc_rdata;
  logic [14:0] ram_addr;
  logic [7:0]  ram_dout, ram_din;
  logic        ram_dq_oe, ram_oe_n, ram_we_n;
  state_e      dbg_state;
  logic        dbg_pend;

  sram_arbiter #(.ACC_CYCLES(4), .WE_FIRST(1), .WE_LAST(2)) dut (
    .clk(clk), .rst(rst),
    .cart_req(cart_req), .cart_we(cart_we), .cart_addr(cart_addr),
    .cart_wdata(cart_wdata), .cart_rdata(cart_rdata), .cart_done(cart_done),
    .cart_wp(cart_wp), .cart_ovf(cart_ovf),
    .uc_req(uc_req), .uc_we(uc_we), .uc_addr(uc_addr), .uc_wdata(uc_wdata),
    .uc_rdata(uc_rdata), .uc_ack(uc_ack),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_din(ram_din),
    .ram_dq_oe(ram_dq_oe), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .dbg_state(dbg_state), .dbg_pend(dbg_pend)
  );

  // ---------------- SRAM model (single writer process) ----------------
  logic [7:0]  mem [0:32767];
  logic        bk_we;
  logic [14:0] bk_addr;
  logic [7:0]  bk_data;
  always @(posedge clk) begin
    if (bk_we) mem[bk_addr] <= bk_data;
    else if (!ram_we_n && ram_dq_oe) mem[ram_addr] <= ram_dout;
  end
  assign ram_din = mem[ram_addr];

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cart request in cycle 0; records WE-low cycles, first done cycle, rdata at cycle 4.
  task automatic cart_access(input logic we, input logic [14:0] addr, input logic [7:0] wd,
                             input logic wp, output int done_cyc, output logic [15:0] we_mask,
                             output logic [7:0] rd4);
    cart_req = 1'b1; cart_we = we; cart_addr = addr; cart_wdata = wd; cart_wp = wp;
    done_cyc = -1; we_mask = '0; rd4 = '0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      cart_req = 1'b0;
      if (!ram_we_n) we_mask[k] = 1'b1;
      if (k == 4) rd4 = cart_rdata;
      if (cart_done && done_cyc < 0) done_cyc = k;
    end
    cart_wp = 1'b0;
  endtask

  // uc request in cycle 0; returns ack cycle, data, and ack one cycle after req drops.
  task automatic uc_access(input logic we, input logic [14:0] addr, input logic [7:0] wd,
                           output int ack_cyc, output logic [7:0] rd, output logic ack_after);
    uc_req = 1'b1; uc_we = we; uc_addr = addr; uc_wdata = wd;
    ack_cyc = -1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (uc_ack) begin
        ack_cyc = k;
        break;
      end
    end
    rd = uc_rdata;
    uc_req = 1'b0;
    tick();
    ack_after = uc_ack;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  int          dc, ua, cd, ndone;
  logic [15:0] wm;
  logic [7:0]  r4, rd;
  logic        aa, ovf3, pend2;
  state_e      st5;

  initial begin
    cart_req = 0; cart_we = 0; cart_addr = '0; cart_wdata = '0; cart_wp = 0;
    uc_req = 0; uc_we = 0; uc_addr = '0; uc_wdata = '0;
    rst = 1'b1;
    bk_we = 1'b1; bk_addr = 15'h1234; bk_data = 8'hA5;
    tick();
    bk_we = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset / idle state
    check("rst_oe_n",   ram_oe_n, 1);
    check("rst_we_n",   ram_we_n, 1);
    check("rst_dq_oe",  ram_dq_oe, 0);
    check("rst_addr",   ram_addr, 0);
    check("rst_dout",   ram_dout, 0);
    check("rst_crdata", cart_rdata, 0);
    check("rst_urdata", uc_rdata, 0);
    check("rst_done",   cart_done, 0);
    check("rst_ack",    uc_ack, 0);
    check("rst_ovf",    cart_ovf, 0);
    check("rst_pend",   dbg_pend, 0);
    check("rst_state",  dbg_state, IDLE);

    // T1: cart read 0x1234 = 0xA5
    exp_q.push_back(8'hA5);
    cart_access(1'b0, 15'h1234, 8'h00, 1'b0, dc, wm, r4);
    check("t1_rdata_c4", r4, exp_q.pop_front());
    check("t1_done_cyc", dc, 5);
    check("t1_no_we",    wm, 16'h0000);

    // T2: cart write 0x3C -> 0x0100, then a protected write
    cart_access(1'b1, 15'h0100, 8'h3C, 1'b0, dc, wm, r4);
    check("t2_we_cycles", wm, 16'h000C);
    check("t2_done_cyc",  dc, 5);
    check("t2_mem",       mem[15'h0100], 8'h3C);
    check("t2_rdata_hold", cart_rdata, 8'hA5);
    cart_access(1'b1, 15'h0100, 8'h77, 1'b1, dc, wm, r4);
    check("t2wp_no_we",  wm, 16'h0000);
    check("t2wp_done",   dc, 5);
    check("t2wp_mem",    mem[15'h0100], 8'h3C);

    // T3: uc write then read of 0x7FFF
    uc_access(1'b1, 15'h7FFF, 8'h5A, ua, rd, aa);
    check("t3w_ack_cyc", ua, 5);
    check("t3w_ack_clr", aa, 0);
    check("t3w_mem",     mem[15'h7FFF], 8'h5A);
    uc_access(1'b0, 15'h7FFF, 8'h00, ua, rd, aa);
    check("t3r_ack_cyc", ua, 5);
    check("t3r_rdata",   rd, 8'h5A);
    check("t3r_ack_clr", aa, 0);

    // T4: cart_req one cycle after a uc read starts
    uc_req = 1'b1; uc_we = 1'b0; uc_addr = 15'h0100;
    ua = -1; cd = -1; pend2 = 1'b0; st5 = IDLE;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (uc_ack && ua < 0) ua = k;
      if (cart_done && cd < 0) cd = k;
      if (k == 2) pend2 = dbg_pend;
      if (k == 5) st5 = dbg_state;
      cart_req = (k == 1); cart_we = 1'b0; cart_addr = 15'h7FFF;
    end
    check("t4_uc_ack_cyc", ua, 5);
    check("t4_pend_c2",    pend2, 1);
    check("t4_state_c5",   st5, CART);
    check("t4_done_cyc",   cd, 9);
    check("t4_uc_rdata",   uc_rdata, 8'h3C);
    check("t4_cart_rdata", cart_rdata, 8'h5A);
    uc_req = 1'b0;
    tick();
    tick();

    // T5: two cart pulses during one uc access
    uc_req = 1'b1; uc_we = 1'b0; uc_addr = 15'h7FFF;
    ndone = 0; ovf3 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (cart_done) ndone++;
      if (k == 3) ovf3 = cart_ovf;
      cart_req  = (k == 1) || (k == 2);
      cart_we   = 1'b0;
      cart_addr = (k == 1) ? 15'h1234 : 15'h0100;
    end
    uc_req = 1'b0;
    tick();
    tick();
    check("t5_ovf_c3",    ovf3, 1);
    check("t5_done_cnt",  ndone, 1);
    check("t5_rdata",     cart_rdata, 8'hA5);
    check("t5_ovf_stick", cart_ovf, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_ovf_rst",   cart_ovf, 0);
    tick();

    // T6: reset during phase 1 of a cart write with a command pending
    cart_req = 1'b1; cart_we = 1'b1; cart_addr = 15'h0200; cart_wdata = 8'h11; cart_wp = 1'b0;
    tick();
    cart_req = 1'b1; cart_we = 1'b0; cart_addr = 15'h1234;
    tick();
    cart_req = 1'b0;
    check("t6_we_low_pre", ram_we_n, 0);
    check("t6_pend_pre",   dbg_pend, 1);
    rst = 1'b1;
    tick();
    check("t6_we_n",  ram_we_n, 1);
    check("t6_dq_oe", ram_dq_oe, 0);
    check("t6_pend",  dbg_pend, 0);
    check("t6_state", dbg_state, IDLE);
    check("t6_addr",  ram_addr, 0);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (cart_done) ndone++;
    end
    check("t6_no_done", ndone, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
